// File: rtl/apb_cpu_pkg.sv
// Shared definitions for the APB master CPU: opcodes, ALU functions,
// control states, error causes and instruction field positions.
package apb_cpu_pkg;

  localparam int unsigned INST_W  = 24;

  // Instruction field bit positions
  localparam int unsigned OP_MSB  = 23;
  localparam int unsigned OP_LSB  = 20;
  localparam int unsigned RD_MSB  = 19;
  localparam int unsigned RD_LSB  = 17;
  localparam int unsigned RA_MSB  = 16;
  localparam int unsigned RA_LSB  = 14;
  localparam int unsigned RB_MSB  = 13;
  localparam int unsigned RB_LSB  = 11;
  localparam int unsigned FN_MSB  = 10;
  localparam int unsigned FN_LSB  = 8;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;

  // Opcodes 7..15 are not listed and execute as NOP
  typedef enum logic [3:0] {
    OP_ALU  = 4'd0,
    OP_ADDI = 4'd1,
    OP_BEQ  = 4'd2,
    OP_JMP  = 4'd3,
    OP_APBW = 4'd4,
    OP_APBR = 4'd5,
    OP_HALT = 4'd6
  } op_e;

  typedef enum logic [2:0] {
    FN_ADD  = 3'd0,
    FN_SUB  = 3'd1,
    FN_AND  = 3'd2,
    FN_OR   = 3'd3,
    FN_XOR  = 3'd4,
    FN_SHL1 = 3'd5,
    FN_SHR1 = 3'd6,
    FN_SLT  = 3'd7
  } func_e;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_EXEC,
    ST_SETUP,
    ST_ACCESS,
    ST_HALT
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_SLVERR  = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_e;

endpackage

// File: rtl/apb_master_cpu_if.sv
// APB bus bundle between the CPU (master) and its peripheral bridge (slave).
interface apb_master_cpu_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_cpu_regfile.sv
// Register file: two combinational read ports, one synchronous write port.
// r0 and any index >= NREGS read as zero and ignore writes.
module apb_cpu_regfile #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREGS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        ra_addr,
  input  logic [2:0]        rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [DATA_W-1:0] wdata
);

  // No storage for r0; the array starts at index 1
  logic [DATA_W-1:0] regs [1:NREGS-1];

  // Clear on reset, write the addressed register when enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 1; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      for (int unsigned i = 1; i < NREGS; i++)
        if (waddr == 3'(i)) regs[i] <= wdata;
    end
  end

  // Read ports: unmatched indices (r0, out of range) fall through to zero
  always_comb begin
    ra_data = '0;
    rb_data = '0;
    for (int unsigned i = 1; i < NREGS; i++) begin
      if (ra_addr == 3'(i)) ra_data = regs[i];
      if (rb_addr == 3'(i)) rb_data = regs[i];
    end
  end

endmodule

// File: rtl/apb_master_cpu.sv
// Multi-cycle CPU core with an APB master for load/store instructions.
// FETCH -> EXEC for register ops; EXEC -> SETUP -> ACCESS for bus ops.
module apb_master_cpu
  import apb_cpu_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NREGS   = 8,
  parameter int unsigned PC_W    = 8,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_inst,
  apb_master_cpu_if.master  apb,
  output logic              retire,
  output logic              halted,
  output logic [1:0]        err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  err_e              err_q, err_d;
  logic              retire_q, retire_d;
  logic [CNT_W-1:0]  wait_q, wait_d;

  // Decoded instruction fields
  op_e               op;
  func_e             fn;
  logic [2:0]        rd_idx, ra_idx, rb_idx;
  logic signed [7:0] imm_s;
  logic [DATA_W-1:0] imm_d;
  logic [PC_W-1:0]   imm_pc;

  assign op     = op_e'(ir_q[OP_MSB:OP_LSB]);
  assign fn     = func_e'(ir_q[FN_MSB:FN_LSB]);
  assign rd_idx = ir_q[RD_MSB:RD_LSB];
  assign ra_idx = ir_q[RA_MSB:RA_LSB];
  assign rb_idx = ir_q[RB_MSB:RB_LSB];
  assign imm_s  = ir_q[IMM_MSB:IMM_LSB];
  assign imm_d  = DATA_W'(imm_s);
  assign imm_pc = PC_W'(imm_s);

  logic [DATA_W-1:0] ra_val, rb_val, alu_res, ea_sum;
  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;

  apb_cpu_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (ra_idx),
    .rb_addr (rb_idx),
    .ra_data (ra_val),
    .rb_data (rb_val),
    .we      (rf_we),
    .waddr   (rd_idx),
    .wdata   (rf_wdata)
  );

  assign ea_sum = ra_val + imm_d;

  // ALU: all results wrap to DATA_W bits
  always_comb begin
    alu_res = '0;
    case (fn)
      FN_ADD:  alu_res = ra_val + rb_val;
      FN_SUB:  alu_res = ra_val - rb_val;
      FN_AND:  alu_res = ra_val & rb_val;
      FN_OR:   alu_res = ra_val | rb_val;
      FN_XOR:  alu_res = ra_val ^ rb_val;
      FN_SHL1: alu_res = ra_val << 1;
      FN_SHR1: alu_res = ra_val >> 1;
      FN_SLT:  alu_res = DATA_W'(ra_val < rb_val);
      default: alu_res = '0;
    endcase
  end

  // Next-state, datapath updates and register-file write control
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    err_d    = err_q;
    retire_d = 1'b0;
    wait_d   = wait_q;
    rf_we    = 1'b0;
    rf_wdata = alu_res;
    case (state_q)
      ST_FETCH: begin
        ir_d    = imem_inst;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (op)
          OP_ALU: begin
            rf_we    = 1'b1;
            pc_d     = pc_q + PC_W'(1);
            retire_d = 1'b1;
            state_d  = ST_FETCH;
          end
          OP_ADDI: begin
            rf_we    = 1'b1;
            rf_wdata = ea_sum;
            pc_d     = pc_q + PC_W'(1);
            retire_d = 1'b1;
            state_d  = ST_FETCH;
          end
          OP_BEQ: begin
            pc_d     = (ra_val == rb_val) ? pc_q + imm_pc : pc_q + PC_W'(1);
            retire_d = 1'b1;
            state_d  = ST_FETCH;
          end
          OP_JMP: begin
            pc_d     = imm_pc;
            retire_d = 1'b1;
            state_d  = ST_FETCH;
          end
          OP_APBW, OP_APBR: begin
            paddr_d  = ADDR_W'(ea_sum);
            pwdata_d = rb_val;
            pwrite_d = (op == OP_APBW);
            wait_d   = '0;
            state_d  = ST_SETUP;
          end
          OP_HALT: begin
            retire_d = 1'b1;
            state_d  = ST_HALT;
          end
          default: begin
            pc_d     = pc_q + PC_W'(1);
            retire_d = 1'b1;
            state_d  = ST_FETCH;
          end
        endcase
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (apb.pready) begin
          if (apb.pslverr) begin
            err_d   = ERR_SLVERR;
            state_d = ST_HALT;
          end else begin
            rf_we    = !pwrite_q;
            rf_wdata = apb.prdata;
            pc_d     = pc_q + PC_W'(1);
            retire_d = 1'b1;
            state_d  = ST_FETCH;
          end
        end else if (wait_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_HALT;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // State and datapath registers; reset abandons any bus transfer at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      err_q    <= ERR_NONE;
      retire_q <= 1'b0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      err_q    <= err_d;
      retire_q <= retire_d;
      wait_q   <= wait_d;
    end
  end

  // psel/penable decode straight from state so an async reset drops them immediately
  assign imem_addr   = pc_q;
  assign apb.psel    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign apb.penable = (state_q == ST_ACCESS);
  assign apb.pwrite  = pwrite_q;
  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;
  assign retire      = retire_q;
  assign halted      = (state_q == ST_HALT);
  assign err         = err_q;

endmodule

// File: tb/tb_apb_master_cpu.sv
// Bench for apb_master_cpu: an instruction-level model expands each
// instruction into its expected per-cycle outputs and a scripted APB
// slave answers each transfer from a table of wait/error/data entries.
module tb_apb_master_cpu;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  imem_addr;
  logic [23:0] imem_inst;
  logic        retire, halted;
  logic [1:0]  err;

  apb_master_cpu_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  apb_master_cpu #(
    .DATA_W  (8),
    .NREGS   (8),
    .PC_W    (8),
    .ADDR_W  (8),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem_addr (imem_addr),
    .imem_inst (imem_inst),
    .apb       (bus),
    .retire    (retire),
    .halted    (halted),
    .err       (err)
  );

  always #5 clk = ~clk;

  logic [23:0] rom [256];
  assign imem_inst = rom[imem_addr];

  int checks   = 0;
  int failures = 0;

  // Slave script, one entry per transfer in program order
  int         s_wait [32];
  bit         s_err  [32];
  logic [7:0] s_rd   [32];
  int         s_idx, s_cur, s_acc;

  // Instruction-level model state
  typedef struct {
    logic [7:0] pc, paddr, pwdata;
    bit         psel, pen, pwrite, retire, halted;
    logic [1:0] err;
  } exp_t;

  exp_t       q[$];
  logic [7:0] m_pc, m_paddr, m_pwdata;
  logic [7:0] m_regs [8];
  bit         m_pwrite, m_halted, m_ret;
  logic [1:0] m_err;
  int         m_xfer;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] enc(input int op, input int rd, input int ra,
                                      input int rb, input int fn, input int imm);
    return {op[3:0], rd[2:0], ra[2:0], rb[2:0], fn[2:0], imm[7:0]};
  endfunction

  function automatic logic [7:0] m_alu(input int fn, input logic [7:0] a, input logic [7:0] b);
    case (fn)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a << 1;
      6: return a >> 1;
      default: return (a < b) ? 8'd1 : 8'd0;
    endcase
  endfunction

  task automatic m_wr(input int rd, input logic [7:0] v);
    if (rd != 0) m_regs[rd] = v;
  endtask

  task automatic m_push(input bit psel, input bit pen);
    exp_t e;
    e.pc = m_pc; e.paddr = m_paddr; e.pwdata = m_pwdata;
    e.psel = psel; e.pen = pen; e.pwrite = m_pwrite;
    e.retire = m_ret; e.halted = m_halted; e.err = m_err;
    m_ret = 0;
    q.push_back(e);
  endtask

  // Expand the next instruction into its expected cycles
  task automatic m_gen();
    logic [23:0] in;
    logic [7:0]  imm, av, bv;
    int          op, rd, ra, rb, fn, w, n;
    if (m_halted) begin
      m_push(0, 0);
      return;
    end
    in  = rom[m_pc];
    op  = int'(in[23:20]); rd = int'(in[19:17]); ra = int'(in[16:14]);
    rb  = int'(in[13:11]); fn = int'(in[10:8]);  imm = in[7:0];
    av  = m_regs[ra];
    bv  = m_regs[rb];
    m_push(0, 0);
    m_push(0, 0);
    case (op)
      0: begin m_wr(rd, m_alu(fn, av, bv)); m_pc = m_pc + 8'd1; m_ret = 1; end
      1: begin m_wr(rd, av + imm); m_pc = m_pc + 8'd1; m_ret = 1; end
      2: begin m_pc = (av == bv) ? m_pc + imm : m_pc + 8'd1; m_ret = 1; end
      3: begin m_pc = imm; m_ret = 1; end
      4, 5: begin
        m_paddr = av + imm; m_pwdata = bv; m_pwrite = (op == 4);
        m_push(1, 0);
        w = s_wait[m_xfer];
        n = (w >= TIMEOUT) ? TIMEOUT : w + 1;
        repeat (n) m_push(1, 1);
        if (w >= TIMEOUT) begin
          m_err = 2; m_halted = 1;
        end else if (s_err[m_xfer]) begin
          m_err = 1; m_halted = 1;
        end else begin
          if (op == 5) m_wr(rd, s_rd[m_xfer]);
          m_pc = m_pc + 8'd1; m_ret = 1;
        end
        m_xfer++;
      end
      6: begin m_halted = 1; m_ret = 1; end
      default: begin m_pc = m_pc + 8'd1; m_ret = 1; end
    endcase
  endtask

  task automatic compare_cycle();
    exp_t e;
    if (q.size() == 0) m_gen();
    e = q.pop_front();
    chk("imem_addr", imem_addr, e.pc);
    chk("psel", bus.psel, e.psel);
    chk("penable", bus.penable, e.pen);
    chk("pwrite", bus.pwrite, e.pwrite);
    chk("paddr", bus.paddr, e.paddr);
    chk("pwdata", bus.pwdata, e.pwdata);
    chk("retire", retire, e.retire);
    chk("halted", halted, e.halted);
    chk("err", err, e.err);
  endtask

  task automatic slave_drive();
    if (bus.psel && !bus.penable) begin
      s_cur = s_idx; s_idx++; s_acc = 0;
    end
    if (bus.psel && bus.penable) begin
      bus.pready  = (s_acc == s_wait[s_cur]);
      bus.pslverr = bus.pready && s_err[s_cur];
      bus.prdata  = s_rd[s_cur];
      s_acc++;
    end else begin
      bus.pready  = 1'b0;
      bus.pslverr = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_cycle();
    slave_drive();
  endtask

  task automatic clear_program();
    foreach (rom[i]) rom[i] = enc(15, 0, 0, 0, 0, 0);
    foreach (s_wait[i]) begin s_wait[i] = 0; s_err[i] = 0; s_rd[i] = 8'h00; end
  endtask

  // Assert reset, check the reset outputs, compare the first FETCH cycle, release
  task automatic do_reset();
    rst_n = 1'b0;
    bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = 8'h00;
    q.delete();
    m_pc = 0; m_paddr = 0; m_pwdata = 0; m_pwrite = 0;
    m_halted = 0; m_ret = 0; m_err = 0; m_xfer = 0;
    foreach (m_regs[i]) m_regs[i] = 8'h00;
    s_idx = 0; s_cur = 0; s_acc = 0;
    #1;
    chk("rst_psel", bus.psel, 1'b0);
    chk("rst_penable", bus.penable, 1'b0);
    chk("rst_pwrite", bus.pwrite, 1'b0);
    chk("rst_paddr", bus.paddr, 8'h00);
    chk("rst_pwdata", bus.pwdata, 8'h00);
    chk("rst_imem_addr", imem_addr, 8'h00);
    chk("rst_retire", retire, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_err", err, 2'd0);
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int p, pen_cnt, seen;
    logic [7:0] prev;

    bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = 8'h00;

    // Test A: ALU/ADDI basics, APBW with waits, APBR, APBR to r0, ALU funcs
    clear_program();
    p = 0;
    rom[p++] = enc(1, 1, 0, 0, 0, 5);
    rom[p++] = enc(1, 2, 0, 0, 0, 8'hFD);
    rom[p++] = enc(0, 3, 1, 2, 0, 0);
    rom[p++] = enc(1, 1, 0, 0, 0, 8'h10);
    rom[p++] = enc(1, 5, 0, 0, 0, 8'hA5);
    rom[p++] = enc(4, 0, 1, 5, 0, 4);       s_wait[0] = 2;
    rom[p++] = enc(5, 4, 0, 0, 0, 8'h20);   s_rd[1] = 8'h3C;
    rom[p++] = enc(5, 0, 0, 0, 0, 8'h21);   s_wait[2] = 1; s_rd[2] = 8'h77;
    rom[p++] = enc(4, 0, 0, 3, 0, 8'h30);
    rom[p++] = enc(4, 0, 0, 4, 0, 8'h31);
    rom[p++] = enc(4, 0, 0, 0, 0, 8'h32);
    for (int f = 0; f < 8; f++) begin
      rom[p++] = enc(0, 7, 5, 4, f, 0);
      rom[p++] = enc(4, 0, 0, 7, 0, 8'h40 + f);
    end
    rom[p++] = enc(6, 0, 0, 0, 0, 0);
    #2;
    do_reset();
    pen_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus.penable && bus.paddr == 8'h14) begin
        pen_cnt++;
        if (pen_cnt == 1) begin
          chk("apbw_pwdata", bus.pwdata, 8'hA5);
          chk("apbw_pwrite", bus.pwrite, 1'b1);
        end
      end
      if (bus.penable && bus.paddr == 8'h30) chk("r3_sum_out", bus.pwdata, 8'h02);
      if (bus.penable && bus.paddr == 8'h31) chk("r4_read_out", bus.pwdata, 8'h3C);
      if (bus.penable && bus.paddr == 8'h32) chk("r0_after_apbr", bus.pwdata, 8'h00);
    end
    chk("apbw_penable_cycles", pen_cnt, 3);
    chk("model_r3", m_regs[3], 8'h02);
    chk("model_r4", m_regs[4], 8'h3C);
    chk("halt_op_halted", halted, 1'b1);

    // Test B: JMP, BEQ taken backwards, BEQ not taken, PC wrap
    clear_program();
    rom[0]   = enc(1, 1, 0, 0, 0, 1);
    rom[1]   = enc(1, 2, 0, 0, 0, 1);
    rom[2]   = enc(3, 0, 0, 0, 0, 5);
    rom[3]   = enc(1, 3, 3, 0, 0, 1);
    rom[4]   = enc(2, 0, 3, 2, 0, 3);
    rom[5]   = enc(2, 0, 1, 2, 0, 8'hFE);
    rom[7]   = enc(2, 0, 1, 0, 0, 5);
    rom[8]   = enc(3, 0, 0, 0, 0, 8'hFF);
    rom[255] = enc(1, 4, 0, 0, 0, 9);
    do_reset();
    prev = imem_addr;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (imem_addr != prev) begin
        if (prev == 8'd5 && !seen[0]) begin chk("beq_taken_pc", imem_addr, 8'd3); seen[0] = 1; end
        if (prev == 8'd7 && !seen[1]) begin chk("beq_not_taken_pc", imem_addr, 8'd8); seen[1] = 1; end
        if (prev == 8'hFF && !seen[2]) begin chk("pc_wrap", imem_addr, 8'd0); seen[2] = 1; end
      end
      prev = imem_addr;
    end
    chk("branch_points_seen", seen, 7);

    // Test C: PSLVERR on APBR halts with rd untouched and PC on the load
    clear_program();
    rom[0] = enc(1, 4, 0, 0, 0, 8'h11);
    rom[1] = enc(5, 4, 0, 0, 0, 8'h50);
    s_wait[0] = 1; s_err[0] = 1; s_rd[0] = 8'hEE;
    do_reset();
    for (int i = 0; i < 20; i++) step();
    chk("slverr_err", err, 2'd1);
    chk("slverr_pc", imem_addr, 8'd1);
    chk("slverr_rd_kept", dut.u_rf.regs[4], 8'h11);

    // Test D: PREADY stuck low times out after TIMEOUT ACCESS cycles
    clear_program();
    rom[0] = enc(4, 0, 0, 0, 0, 8'h70);
    s_wait[0] = 255;
    do_reset();
    pen_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.penable) pen_cnt++;
    end
    chk("timeout_access_cycles", pen_cnt, 16);
    chk("timeout_err", err, 2'd2);
    chk("timeout_halted", halted, 1'b1);

    // Test E: reset in the middle of ACCESS, then normal execution resumes
    clear_program();
    rom[0] = enc(1, 1, 0, 0, 0, 7);
    rom[1] = enc(5, 2, 1, 0, 0, 8'h60);
    rom[2] = enc(4, 0, 0, 2, 0, 8'h61);
    rom[3] = enc(6, 0, 0, 0, 0, 0);
    s_wait[0] = 255;
    do_reset();
    pen_cnt = 0;
    for (int i = 0; i < 40 && pen_cnt < 4; i++) begin
      step();
      if (bus.penable) pen_cnt++;
    end
    chk("reached_access", pen_cnt, 4);
    chk("access_paddr", bus.paddr, 8'h67);
    s_wait[0] = 0; s_rd[0] = 8'h99;
    #2;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.penable && bus.paddr == 8'h61) chk("resume_pwdata", bus.pwdata, 8'h99);
    end
    chk("resume_model_r2", m_regs[2], 8'h99);
    chk("resume_halted", halted, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_master_cpu.md
Name: apb_master_cpu

Overview:
- Parametrised, multi-cycle successor to the team's 8-bit APB-capable CPU core.
- Fetches 24-bit instructions from an external instruction ROM and executes ALU, branch, jump and halt operations on an internal register file.
- Load/store instructions become true AMBA APB master transfers (SETUP/ACCESS with PREADY wait states, PSLVERR and a timeout).
- Sits between the instruction ROM and the APB bus (UART/I2C bridge slaves).

Parameters:
- DATA_W, 8: register, ALU and PWDATA/PRDATA width (8..32).
- NREGS, 8: register count (2..8; index field is 3 bits); r0 reads 0, writes ignored.
- PC_W, 8: program counter / imem address width.
- ADDR_W, 8: PADDR width.
- TIMEOUT, 16: maximum ACCESS cycles waiting for PREADY before abort (>=1).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  PC_W  instruction address (= PC).
- imem_inst  in  24  instruction; combinational ROM, valid same cycle.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction (1 = write).
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB slave ready.
- pslverr  in  1  APB slave error.
- retire  out  1  one-cycle pulse per completed instruction.
- halted  out  1  core stopped (HALT instruction or error).
- err  out  2  sticky cause: 0 none, 1 PSLVERR, 2 timeout.

Behaviour:
- Encoding: [23:20] op, [19:17] rd, [16:14] ra, [13:11] rb, [10:8] func, [7:0] imm. imm is sign-extended to DATA_W; for PC use it is truncated/extended to PC_W. Register indices >= NREGS read 0 and ignore writes.
- Ops:
  - 0 ALU: rd = ra func rb. func: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl1, 6 shr1 (logical), 7 slt (unsigned, result 0/1). Results wrap modulo 2^DATA_W.
  - 1 ADDI: rd = ra + imm.
  - 2 BEQ: if ra == rb, pc = pc + imm (signed); else pc + 1.
  - 3 JMP: pc = imm.
  - 4 APBW: paddr = ra + imm (low ADDR_W bits), pwdata = rb.
  - 5 APBR: paddr = ra + imm; rd = prdata.
  - 6 HALT.
  - 7..15 NOP.
- FSM states: FETCH, EXEC, SETUP, ACCESS, HALT.
  - FETCH -> EXEC: latch imem_inst into the IR.
  - EXEC, non-APB op: write rd, update PC, pulse retire, -> FETCH. Each non-APB instruction takes 2 cycles.
  - EXEC, APBW/APBR: register paddr/pwdata/pwrite, -> SETUP. psel=1, penable=0 in SETUP.
  - SETUP -> ACCESS: psel=1, penable=1. Address, data and direction stay stable through SETUP and ACCESS.
  - ACCESS with pready=1 and pslverr=0: read data written to rd, PC+1, retire pulse, psel and penable drop next cycle, -> FETCH. Zero-wait transfer = 4 cycles per instruction.
  - ACCESS with pready=1 and pslverr=1: no register write, PC unchanged (points at the faulting instruction), err=1, -> HALT.
  - ACCESS after TIMEOUT cycles with pready=0: bus released, err=2, -> HALT. Wait counter resets on each SETUP entry.
  - HALT: halted=1, no bus activity; left only by reset. The HALT op itself pulses retire; PC remains at the HALT instruction.
- PC wraps modulo 2^PC_W on both increment and branch.
- Reset, including mid-transfer: asynchronous. PC=0, state FETCH, all registers 0, psel=penable=pwrite=0, paddr=pwdata=0, retire=0, halted=0, err=0. A bus transfer in flight is abandoned immediately.
- Write to r0 together with an APBR: the bus transfer still occurs, the data is discarded.

Decomposition:
- Package apb_cpu_pkg holds:
  - opcode and func enums;
  - the state enum;
  - the instruction field-slice constants;
  - the err codes.
- One sub-module, apb_cpu_regfile: two combinational read ports, one synchronous write port, r0 hardwired to 0. The ALU stays inline.

Test Plan:
- Reset, then ADDI r1,r0,5; ADDI r2,r0,-3; ALU add r3,r1,r2 -> r3=2, retire every 2 cycles, imem_addr 0,1,2.
- APBW with r1=0x10, imm 4, rb=0xA5, pready low for 2 cycles -> paddr=0x14, pwdata=0xA5, pwrite=1, penable high 3 cycles, retire after the 3rd.
- APBR at 0x20 with prdata=0x3C, zero wait -> r4=0x3C 4 cycles after fetch; APBR to r0 -> r0 stays 0.
- BEQ taken with imm=-2 at pc=5 -> pc=3; JMP 0xFF then ADDI -> next pc wraps to 0x00.
- pslverr=1 on APBR -> rd unchanged, err=1, halted=1, pc stays at the instruction, no further psel; pready stuck low -> err=2 after 16 ACCESS cycles.
- rst_n asserted during ACCESS -> psel and penable drop in the same cycle, pc=0; after release, normal fetch resumes.
